// File: rtl/divmod_seq.sv
// divmod_seq: sequential restoring unsigned divider, Q = N / D and R = N % D in WIDTH+1 cycles.
// Optional macro DIVMOD_ZERO_FAST_EN: a zero divisor skips the iterations and reports div_zero.
module divmod_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] D,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] num_q, den_q, rem_q, rem_d, q_q, r_q;
    logic             busy_q, done_q, ge_d;
    logic [WIDTH:0]   trial_d;
    // one restoring step: shift the next dividend bit into the working remainder and trial-subtract
    always_comb begin
        trial_d = {rem_q, num_q[WIDTH-1]};
        ge_d    = trial_d >= {1'b0, den_q};
        rem_d   = ge_d ? trial_d[WIDTH-1:0] - den_q : trial_d[WIDTH-1:0];
    end
`ifdef DIVMOD_ZERO_FAST_EN
    logic dz_q;
    // div_zero is published together with Q and R on the done edge
    always_ff @(posedge clk or posedge rst)
        if (rst) dz_q <= 1'b0;
        else if (state_q == RUN && cnt_q == CW'(WIDTH)) dz_q <= den_q == '0;
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif
    // control FSM with datapath; num_q doubles as dividend shifter and quotient accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == RUN) begin
                if (cnt_q == CW'(WIDTH)) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    q_q     <= num_q;
                    r_q     <= rem_q;
                end else begin
                    num_q <= {num_q[WIDTH-2:0], ge_d};
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + CW'(1);
                end
            end else if (start) begin
                state_q <= RUN;
                busy_q  <= 1'b1;
                num_q   <= N;
                den_q   <= D;
                rem_q   <= '0;
                cnt_q   <= '0;
`ifdef DIVMOD_ZERO_FAST_EN
                if (D == '0) begin
                    num_q <= '1;
                    rem_q <= N;
                    cnt_q <= CW'(WIDTH);
                end
`endif
            end else begin
                state_q <= IDLE;
            end
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
endmodule

// File: tb/tb_divmod_seq.sv
// tb_divmod_seq: directed checks of divmod_seq latency, results, ignore-while-busy, back-to-back and reset abort.
module tb_divmod_seq;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [7:0] N = '0, D = '0, Q, R;
    logic       busy, done, div_zero;
    int         n_chk = 0, n_fail = 0, lat;

    divmod_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .N(N), .D(D),
        .busy(busy), .done(done), .Q(Q), .R(R), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int l);
        l = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (done) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic launch(input logic [7:0] n, input logic [7:0] d);
        N = n;
        D = d;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic op(input string tag, input logic [7:0] n, input logic [7:0] d,
                      input logic [7:0] eq, input logic [7:0] er);
        launch(n, d);
        wait_done(lat);
        chk({tag, "_lat"}, lat, 9);
        chk({tag, "_q"}, Q, eq);
        chk({tag, "_r"}, R, er);
    endtask

    initial begin
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", Q, 0);
        chk("rst_r", R, 0);
        chk("rst_dz", div_zero, 0);
        step();
        step();
        rst = 1'b0;
        // 200/7, operands scrambled after acceptance
        launch(200, 7);
        N = 8'hAA;
        D = 8'h01;
        chk("s1_busy_e0", busy, 1);
        step();
        chk("s1_busy_e1", busy, 1);
        step();
        step();
        step();
        chk("s1_q_stable", Q, 0);
        step();
        step();
        step();
        step();
        chk("s1_busy_e8", busy, 1);
        chk("s1_done_e8", done, 0);
        step();
        chk("s1_done_e9", done, 1);
        chk("s1_busy_e9", busy, 0);
        chk("s1_q", Q, 28);
        chk("s1_r", R, 4);
        step();
        chk("s1_done_pulse", done, 0);
        op("s2", 255, 1, 255, 0);
        op("s3", 5, 9, 0, 5);
        op("n0", 0, 5, 0, 0);
        op("eq", 200, 200, 1, 0);
        op("max", 255, 255, 1, 0);
        op("m3", 250, 16, 15, 10);
        // zero divisor
        launch(77, 0);
        wait_done(lat);
`ifdef DIVMOD_ZERO_FAST_EN
        chk("z_lat", lat, 1);
        chk("z_dz", div_zero, 1);
`else
        chk("z_lat", lat, 9);
        chk("z_dz", div_zero, 0);
`endif
        chk("z_q", Q, 255);
        chk("z_r", R, 77);
        // start held while busy must not disturb 100/3
        launch(100, 3);
        N = 9;
        D = 9;
        start = 1'b1;
        for (int k = 0; k < 8; k++) step();
        chk("hold_q_stable", Q, 255);
        start = 1'b0;
        wait_done(lat);
        chk("hold_lat", lat, 1);
        chk("hold_q", Q, 33);
        chk("hold_r", R, 1);
        wait_done(lat);
        chk("hold_single_done", lat, -1);
        // back-to-back: start issued in the DONE cycle
        launch(200, 7);
        wait_done(lat);
        chk("bb1_lat", lat, 9);
        launch(9, 9);
        chk("bb_q_hold", Q, 28);
        wait_done(lat);
        chk("bb2_lat", lat, 9);
        chk("bb2_q", Q, 1);
        chk("bb2_r", R, 0);
        // reset abort mid-run
        launch(200, 7);
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", Q, 0);
        chk("abort_r", R, 0);
        step();
        step();
        chk("abort_no_done", done, 0);
        rst = 1'b0;
        op("post_rst", 10, 3, 3, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
